// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store unit.
// Holds funct3 codes, FSM states, the latched request and lane helpers.
package mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int WA_MAX = 30;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        DONE
    } mau_state_e;

    typedef struct packed {
        logic              we;
        logic [WA_MAX-1:0] waddr;
        logic [3:0]        be;
        logic [31:0]       wdata;
        logic [2:0]        funct3;
        logic [1:0]        off;
    } mem_req_t;

    function automatic logic acc_legal(
        input logic       we,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic ok;
        ok = 1'b0;
        if (we) begin
            case (f3)
                SB:      ok = 1'b1;
                SH:      ok = ~off[0];
                SW:      ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (f3)
                LB, LBU: ok = 1'b1;
                LH, LHU: ok = ~off[0];
                LW:      ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [3:0] store_be(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic [3:0] be;
        case (f3)
            SB:      be = 4'b0001 << off;
            SH:      be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(
        input logic [2:0]  f3,
        input logic [31:0] wd
    );
        logic [31:0] d;
        case (f3)
            SB:      d = {4{wd[7:0]}};
            SH:      d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half of a read word and extends it.
// Purely combinational; undefined funct3 passes the word through.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            LB:      data_o = {{24{byte_sel[7]}}, byte_sel};
            LBU:     data_o = {24'd0, byte_sel};
            LH:      data_o = {{16{half_sel[15]}}, half_sel};
            LHU:     data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: request/grant/response handshake to data memory,
// pipeline stall while busy, load extension and error reporting.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [2:0]            funct3,
    output logic                  stall,
    output logic [DATA_W-1:0]     load_data,
    output logic                  access_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DM_ADDRESS-3:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    mau_state_e  state_q, state_d;
    mem_req_t    req_q, req_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] ld_q, ld_d;
    logic [31:0] aligned;
    logic        new_we;
    logic        in_req;
    logic        expired;
    logic        unused_waddr;

    assign new_we  = req_write;
    assign in_req  = (state_q == REQ);
    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    mem_load_align u_align (
        .rdata_i  (mem_rdata),
        .off_i    (req_q.off),
        .funct3_i (req_q.funct3),
        .data_o   (aligned)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        ld_d       = ld_q;
        stall      = 1'b0;
        access_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_read | req_write) begin
                    if (acc_legal(new_we, funct3, addr[1:0])) begin
                        req_d.we     = new_we;
                        req_d.waddr  = WA_MAX'(addr[DM_ADDRESS-1:2]);
                        req_d.be     = store_be(funct3, addr[1:0]);
                        req_d.wdata  = store_data(funct3, wdata);
                        req_d.funct3 = funct3;
                        req_d.off    = addr[1:0];
                        cnt_d        = '0;
                        stall        = 1'b1;
                        state_d      = REQ;
                    end else begin
                        access_err = 1'b1;
                        ld_d       = '0;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = req_q.we ? DONE : WAIT_R;
                end else if (expired) begin
                    access_err = 1'b1;
                    ld_d       = '0;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_R: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    ld_d    = aligned;
                    state_d = DONE;
                end else if (expired) begin
                    access_err = 1'b1;
                    ld_d       = '0;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
        end
    end

    // Memory-side outputs are only live while a request is presented.
    assign mem_req   = in_req;
    assign mem_we    = in_req & req_q.we;
    assign mem_addr  = in_req ? req_q.waddr[DM_ADDRESS-3:0] : '0;
    assign mem_be    = in_req ? req_q.be : 4'b0000;
    assign mem_wdata = in_req ? req_q.wdata : '0;
    assign load_data = ld_q;

    assign unused_waddr = ^req_q.waddr[WA_MAX-1:DM_ADDRESS-2];

endmodule
